// File: rtl/styler_serializer.sv
// Glyph-row serializer: buffers one styled cell word and shifts it out MSB-first per pixel enable.
// Define STYLER_SERIALIZER_PHASE_EN to generate the faint/blink/cursor frame phase outputs.
module styler_serializer #(
  parameter int unsigned CELL_W     = 16,
  parameter int unsigned BLINK_DIV  = 32,
  parameter int unsigned CURSOR_DIV = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_bitmap,
  input  logic        in_last,
  input  logic        pix_en,
  output logic        pix_out,
  output logic        pix_valid,
  output logic        line_end,
  output logic        underrun,
  input  logic        frame_start,
  output logic        faint_phase,
  output logic        blink_phase,
  output logic        cursor_phase
);

  localparam int unsigned CntW    = 4;
  localparam logic [CntW-1:0] LastPix = CntW'(CELL_W - 1);

  logic [15:0]     holdBitmap;
  logic            holdLast;
  logic            holdFull;
  logic [15:0]     shReg;
  logic            shLast;
  logic            shFull;
  logic [CntW-1:0] pixCnt;
  logic            lineActive;

  logic accept;
  logic cellDone;
  logic move;

  assign in_ready = ~holdFull & ~rst;
  assign accept   = in_valid & in_ready;
  assign cellDone = shFull & pix_en & (pixCnt == LastPix);
  // Reload on the last pixel keeps consecutive cells gap-free.
  assign move     = holdFull & (~shFull | cellDone);

  always_ff @(posedge clk) begin
    if (rst) begin
      holdBitmap <= '0;
      holdLast   <= 1'b0;
      holdFull   <= 1'b0;
      shReg      <= '0;
      shLast     <= 1'b0;
      shFull     <= 1'b0;
      pixCnt     <= '0;
      lineActive <= 1'b0;
      pix_out    <= 1'b0;
      pix_valid  <= 1'b0;
      line_end   <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      line_end <= 1'b0;
      underrun <= 1'b0;

      if (accept) begin
        holdBitmap <= in_bitmap;
        holdLast   <= in_last;
        holdFull   <= 1'b1;
      end else if (move) begin
        holdFull <= 1'b0;
      end

      if (pix_en) begin
        if (shFull) begin
          pix_out   <= shReg[15];
          pix_valid <= 1'b1;
          shReg     <= {shReg[14:0], 1'b0};
          pixCnt    <= pixCnt + CntW'(1);
          if (cellDone) begin
            pixCnt   <= '0;
            shFull   <= 1'b0;
            line_end <= shLast;
          end
        end else begin
          // A word waiting in hold is not an underrun; it is one cycle from shifting.
          pix_out   <= 1'b0;
          pix_valid <= 1'b0;
          underrun  <= lineActive & ~holdFull;
        end
      end

      if (move) begin
        shReg  <= holdBitmap;
        shLast <= holdLast;
        shFull <= 1'b1;
        pixCnt <= '0;
      end

      if (accept) begin
        lineActive <= 1'b1;
      end else if (cellDone & shLast) begin
        lineActive <= 1'b0;
      end
    end
  end

`ifdef STYLER_SERIALIZER_PHASE_EN
  logic [7:0] blinkCnt;
  logic [7:0] cursorCnt;

  // Frame-rate phase generators advanced by frame_start.
  always_ff @(posedge clk) begin
    if (rst) begin
      blinkCnt     <= '0;
      cursorCnt    <= '0;
      faint_phase  <= 1'b0;
      blink_phase  <= 1'b0;
      cursor_phase <= 1'b0;
    end else if (frame_start) begin
      faint_phase <= ~faint_phase;
      if (blinkCnt == 8'(BLINK_DIV - 1)) begin
        blinkCnt    <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blinkCnt <= blinkCnt + 8'd1;
      end
      if (cursorCnt == 8'(CURSOR_DIV - 1)) begin
        cursorCnt    <= '0;
        cursor_phase <= ~cursor_phase;
      end else begin
        cursorCnt <= cursorCnt + 8'd1;
      end
    end
  end
`else
  logic unusedPhaseIn;
  assign unusedPhaseIn = frame_start ^ (BLINK_DIV > 255) ^ (CURSOR_DIV > 255);
  assign faint_phase   = 1'b0;
  assign blink_phase   = 1'b0;
  assign cursor_phase  = 1'b0;
`endif

endmodule
